mfsc_feature_streamer: RTL and testbench
========================================

# mfsc_feature_streamer

Transmit-side streamer that feeds 16-bit log10 MFSC coefficients into the feature-map write port of the ShuffleNet memory controller. It buffers coefficients from the log10 unit in a small FIFO. On `start` it drives exactly `FEATURE_LEN` words over the `log10_result` / `log10_result_Rready` / `log10_result_Wready` handshake, then reports completion. It sits between the MFSC log10 stage and the ShuffleNet memory controller.

## Interface
Parameters:
- `DATA_W`, 16, coefficient width
- `DEPTH`, 32, FIFO depth in words (power of two)
- `FEATURE_LEN`, 1600, words per feature map (40 coefficients x 40 frames)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  log10 unit presents `in_data`
- `in_data`  in  DATA_W  coefficient from the log10 unit
- `in_ready`  out  1  FIFO can accept; equals not-full
- `start`  in  1  one-cycle pulse that begins one feature-map transfer
- `log10_result`  out  DATA_W  word presented to the memory controller
- `log10_result_Rready`  out  1  valid flag: `log10_result` holds a word
- `log10_result_Wready`  in  1  memory controller accepts a word this cycle
- `busy`  out  1  high in STREAM
- `feature_sent`  out  1  one-cycle pulse after the final word is accepted
- `overflow`  out  1  sticky; set when a word is offered while the FIFO is full
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Input: a word is written when `in_valid && in_ready`. Input is accepted in every state. Words beyond the current map stay queued for the next map.
- Overflow: if `in_valid && !in_ready`, the word is dropped and `overflow` is set. `overflow` is cleared only by `start` accepted in IDLE, or by `reset`.
- Output stage: a single output register holds `log10_result`, with `Rready` as its valid bit.
  - The register loads from the FIFO when all of these hold: state is STREAM, FIFO is non-empty, the register is empty or handshaking this cycle, and the map is not on its final word.
- Transfer: one word moves on each cycle where `Rready && Wready`.
  - `log10_result` stays stable while `Rready=1 && Wready=0`.
  - `Rready` never drops without a transfer.
- Counter: `sent_cnt` has width $clog2(FEATURE_LEN). It is zeroed on entry to STREAM and increments per transfer.
- FSM:
  - IDLE -> STREAM on `start`.
  - STREAM -> DONE on a transfer with `sent_cnt == FEATURE_LEN-1`.
  - DONE -> IDLE unconditionally.
  - `start` is ignored outside IDLE.
- In DONE: `feature_sent=1` and `Rready=0`. Exactly `FEATURE_LEN` words have been transferred; no extra word is preloaded.
- Simultaneous FIFO push and pop in one cycle: `fifo_level` is unchanged. Push when full is rejected even if a pop occurs in the same cycle.
- Reset, including mid-transfer: asynchronous clear of all state. FIFO contents are discarded and the partial map is abandoned.

## Timing
- Reset values: `log10_result=0`, `log10_result_Rready=0`, `in_ready=1`, `busy=0`, `feature_sent=0`, `overflow=0`, `fifo_level=0`, state IDLE.
- Latency, FIFO empty and STREAM active: word written at edge t is visible at `Rready` in cycle t+2.
- With the FIFO pre-filled, `start` at edge t gives `Rready=1` in cycle t+2.
- Throughput is one word per cycle while the FIFO is non-empty and `Wready` is held high.
- `feature_sent` is high in the cycle after the final transfer. `busy` falls in the same cycle.
- All outputs are registered except `in_ready` and `fifo_level`, which are derived from registered pointers.

## Structure
- Shared package `mfsc_pkg`:
  - `MFSC_DATA_W = 16`
  - `MFSC_FEATURE_LEN = 1600`
  - the state enum IDLE/STREAM/DONE
- Sub-module `sync_fifo`:
  - parameters DATA_W and DEPTH
  - push/pop/full/empty/level outputs
  - pointers one bit wider than the address
  - async active-high reset
- The top holds the FSM, output register, counter and overflow flag.

## Test plan
- Reset mid-stream: pulse `reset` after 5 of 8 transfers -> all outputs return to reset values next cycle; a new `start` with 8 fresh words sends only the fresh words.
- Basic map: `FEATURE_LEN=8`; push 0x0001..0x0008; `start`; `Wready` held 1 -> 8 transfers in 8 consecutive cycles in order; `feature_sent` pulses once; `fifo_level=0`.
- Backpressure: toggle `Wready` randomly, 30% high -> `log10_result` stable whenever `Rready && !Wready`; sequence 0x0001..0x0008 intact with no duplicates.
- Boundary: push 12 words; `start` -> exactly 8 sent and `Rready=0` in DONE; `fifo_level=4`; a second `start` sends words 9-12 and then stalls with `Rready=0`.
- Overflow: `DEPTH=32`, no `start`; push 33 words -> `in_ready=0` after 32; `overflow=1`; the 33rd word is absent from the output; `overflow` clears on `start`.
- Start ignored: pulse `start` during STREAM and during DONE -> no counter reset and no extra transfers.

Source files
------------

// File: rtl/mfsc_pkg.sv
// Shared constants and FSM encoding for the MFSC feature-map streamer.
package mfsc_pkg;
    localparam int MFSC_DATA_W      = 16;
    localparam int MFSC_FEATURE_LEN = 1600;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } mfsc_state_t;
endpackage

// File: rtl/mfsc_feature_streamer_fifo.sv
// Synchronous FIFO with extra-bit pointers; contents are not reset, only the pointers.
module sync_fifo
    import mfsc_pkg::*;
#(
    parameter int DATA_W = MFSC_DATA_W,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mfsc_feature_streamer.sv
// Buffers log10 coefficients and streams exactly FEATURE_LEN of them per start pulse.
module mfsc_feature_streamer
    import mfsc_pkg::*;
#(
    parameter int DATA_W      = MFSC_DATA_W,
    parameter int DEPTH       = 32,
    parameter int FEATURE_LEN = MFSC_FEATURE_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   start,
    output logic [DATA_W-1:0]      log10_result,
    output logic                   log10_result_Rready,
    input  logic                   log10_result_Wready,
    output logic                   busy,
    output logic                   feature_sent,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int CW = $clog2(FEATURE_LEN);
    localparam logic [CW-1:0] LAST = CW'(FEATURE_LEN - 1);

    mfsc_state_t       state;
    logic [CW-1:0]     sent_cnt;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              xfer;
    logic              last_held;
    logic              load;

    assign in_ready  = !fifo_full;
    assign xfer      = log10_result_Rready && log10_result_Wready;
    // Once the final word of the map sits in the register, nothing more is pulled.
    assign last_held = log10_result_Rready && (sent_cnt == LAST);
    assign load      = (state == STREAM) && !fifo_empty &&
                       (!log10_result_Rready || log10_result_Wready) && !last_held;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (load),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            sent_cnt            <= '0;
            log10_result        <= '0;
            log10_result_Rready <= 1'b0;
            busy                <= 1'b0;
            feature_sent        <= 1'b0;
            overflow            <= 1'b0;
        end else begin
            feature_sent <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= STREAM;
                    sent_cnt <= '0;
                    busy     <= 1'b1;
                    overflow <= 1'b0;
                end
                STREAM: if (xfer) begin
                    sent_cnt <= sent_cnt + CW'(1);
                    if (sent_cnt == LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        feature_sent <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                log10_result        <= fifo_data;
                log10_result_Rready <= 1'b1;
            end else if (xfer) begin
                log10_result_Rready <= 1'b0;
            end

            // A drop in the same cycle as a clearing start still leaves the flag set.
            if (in_valid && fifo_full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mfsc_feature_streamer.sv
// Randomized bench for mfsc_feature_streamer against a queue-based reference model.
module tb_mfsc_feature_streamer;
    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int LEN   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [DW-1:0] log10_result;
    logic          rready;
    logic          wready = 1'b0;
    logic          busy;
    logic          feature_sent;
    logic          overflow;
    logic [5:0]    fifo_level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;

    mfsc_feature_streamer #(.DATA_W(DW), .DEPTH(DEPTH), .FEATURE_LEN(LEN)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .start               (start),
        .log10_result        (log10_result),
        .log10_result_Rready (rready),
        .log10_result_Wready (wready),
        .busy                (busy),
        .feature_sent        (feature_sent),
        .overflow            (overflow),
        .fifo_level          (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_data", 32'(log10_result), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sent", 32'(feature_sent), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(fifo_level), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        wready = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Pushes are only issued while idle, so FIFO occupancy equals the model queue size.
    task automatic push_word(input logic [DW-1:0] d);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
        #1 in_valid = 1'b0;
    endtask

    task automatic push_n(input int n, input bit seq, input int base);
        for (int i = 0; i < n; i++)
            push_word(seq ? DW'(base + i) : DW'($urandom));
    endtask

    // Runs one map. pct: Wready high percentage; inj: cycle to pulse start mid-stream;
    // abort_n: reset after that many transfers; budget: cycle bound.
    task automatic run_map(input int pct, input int inj, input int abort_n, input int budget);
        int sent = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        int exp_n;
        bit hold = 1'b0;
        bit done = 1'b0;
        bit aborted = 1'b0;
        logic [DW-1:0] prev = '0;
        logic [DW-1:0] exp_w;
        exp_n = (mq.size() < LEN) ? mq.size() : LEN;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'(m_ovf));
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            start = (cyc == inj);
            if (abort_n >= 0 && sent == abort_n) begin
                reset = 1'b1;
                #1;
                chk_reset_vals();
                mq.delete();
                m_ovf = 1'b0;
                reset = 1'b0;
                start = 1'b0;
                wready = 1'b0;
                aborted = 1'b1;
                done = 1'b1;
            end else if (feature_sent) begin
                done = 1'b1;
                start = 1'b1;
                chk("done_rready", 32'(rready), 0);
                chk("done_busy", 32'(busy), 0);
                chk("done_count", 32'(sent), 32'(LEN));
            end else begin
                chk("busy", 32'(busy), 1);
                if (hold) begin
                    chk("hold_vld", 32'(rready), 1);
                    chk("hold_data", 32'(log10_result), 32'(prev));
                end
                wready = ($urandom_range(99) < pct);
                if (rready && wready) begin
                    if (mq.size() == 0) chk("extra_word", 1, 0);
                    else begin
                        exp_w = mq.pop_front();
                        chk("data", 32'(log10_result), 32'(exp_w));
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    sent++;
                end
                hold = rready && !wready;
                prev = log10_result;
            end
        end
        if (aborted) return;
        if (!done) begin
            if (exp_n == LEN) chk("timeout", 0, 1);
            else begin
                chk("stall_count", 32'(sent), 32'(exp_n));
                chk("stall_rready", 32'(rready), 0);
                chk("stall_busy", 32'(busy), 1);
            end
            start = 1'b0;
            return;
        end
        if (pct == 100 && exp_n == LEN) begin
            chk("latency", 32'(first_cyc), 1);
            chk("throughput", 32'(last_cyc - first_cyc + 1), 32'(LEN));
        end
        @(negedge clk);
        start = 1'b0;
        chk("sent_pulse", 32'(feature_sent), 0);
        chk("idle_rready", 32'(rready), 0);
        repeat (3) @(negedge clk);
        chk("idle_quiet", 32'(rready), 0);
        chk("idle_level", 32'(fifo_level), 32'(mq.size()));
    endtask

    initial begin
        do_reset();

        // Basic map, full throughput, start injected mid-stream
        push_n(8, 1, 1);
        run_map(100, 4, -1, 100);
        chk("basic_level", 32'(fifo_level), 0);

        // Backpressure with a mid-stream start pulse
        push_n(8, 1, 1);
        run_map(30, 3, -1, 400);
        push_n(8, 0, 0);
        run_map(30, 6, -1, 400);

        // Boundary: 12 words, two maps, second one stalls after 4
        push_n(12, 1, 1);
        run_map(100, -1, -1, 100);
        chk("bound_level", 32'(fifo_level), 4);
        run_map(100, -1, -1, 40);
        do_reset();

        // Overflow: 33 pushes into a 32-deep FIFO
        push_n(33, 1, 16'h100);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("ovf_set", 32'(overflow), 32'(m_ovf));
        chk("full_level", 32'(fifo_level), 32);
        for (int m = 0; m < 4; m++) run_map(60, -1, -1, 400);
        chk("drain_level", 32'(fifo_level), 0);

        // Reset mid-stream, then fresh words only
        push_n(8, 1, 16'h200);
        run_map(100, -1, 5, 100);
        push_n(8, 1, 16'h300);
        run_map(100, -1, -1, 100);
        chk("fresh_level", 32'(fifo_level), 0);

        // Random rounds
        for (int r = 0; r < 3; r++) begin
            push_n($urandom_range(14, 8), 0, 0);
            run_map($urandom_range(100, 20), $urandom_range(10), -1, 400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
